// File: rtl/ofm_tx_feeder_pkg.sv
// ofm_tx_feeder_pkg
// Shared constants and types for the OFM transmit feeder.
//   IFCODE_*          : transfer codes understood by the downstream writer
//   WR_SIZE_*         : word count of each transfer type
//   IFSCHEDULE_WIDTH  : width of the schedule tag forwarded with a transfer
//   tx_state_t        : feeder FSM states
//   wr_size_of()      : code -> word count, same decode as the downstream side
package ofm_tx_feeder_pkg;

  localparam logic [3:0] IFCODE_FLGOFM = 4'h6;
  localparam logic [3:0] IFCODE_OFM    = 4'h5;

  localparam int unsigned WR_SIZE_FLGOFM = 12;
  localparam int unsigned WR_SIZE_OFM    = 20;

  localparam int IFSCHEDULE_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREFETCH,
    ST_CFG_WAIT,
    ST_STREAM,
    ST_DONE
  } tx_state_t;

  // Unknown codes fall back to the FLGOFM size, as the writer does.
  function automatic int unsigned wr_size_of(input logic [3:0] code);
    return (code == IFCODE_OFM) ? WR_SIZE_OFM : WR_SIZE_FLGOFM;
  endfunction

endpackage

// File: rtl/ofm_tx_feeder_sync_skid_fifo.sv
// sync_skid_fifo
// Small synchronous FIFO used as the feeder's skid buffer. The head word is
// presented combinationally so the consumer can use it in the same cycle.
//   clk_chip, reset_n_chip : clock, async active-low reset (empties the FIFO)
//   push, push_data        : write one word at the clock edge
//   pop                    : drop the head word at the clock edge
//   head_data              : current head word (undefined when empty)
//   occupancy              : number of stored words, 0..DEPTH
module sync_skid_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk_chip,
  input  logic                     reset_n_chip,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;

  // Storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk_chip) begin
    if (push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_chip or negedge reset_n_chip) begin
    if (!reset_n_chip) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head_data = mem[rd_ptr_reg];
  assign occupancy = count_reg;

endmodule

// File: rtl/ofm_tx_feeder.sv
// ofm_tx_feeder
// Prefetches a transfer's words from the GBF into a skid buffer, waits for
// the async-FIFO writer to be idle, pulses the configuration and streams the
// words over the wr_ready/wr_req handshake.
//   clk_chip, reset_n_chip      : clock, async active-low reset
//   tx_start/tx_code/
//   tx_base_addr/IF_schedule_in : transfer request (sampled in IDLE only)
//   tx_busy, tx_done            : status (busy while not IDLE, done pulse)
//   gbf_rd_en/addr/data         : GBF read port, data one cycle after enable
//   config_ready/paulse/data,
//   IF_schedule                 : configuration handshake with the writer
//   wr_ready, wr_req, wr_data   : word stream to the writer
module ofm_tx_feeder
  import ofm_tx_feeder_pkg::*;
#(
  parameter int SPI_WIDTH      = 32,
  parameter int GBF_ADDR_WIDTH = 12,
  parameter int TX_WIDTH       = 20,
  parameter int SKID_DEPTH     = 4
) (
  input  logic                        clk_chip,
  input  logic                        reset_n_chip,
  input  logic                        tx_start,
  input  logic [3:0]                  tx_code,
  input  logic [GBF_ADDR_WIDTH-1:0]   tx_base_addr,
  input  logic [IFSCHEDULE_WIDTH-1:0] IF_schedule_in,
  output logic                        tx_busy,
  output logic                        tx_done,
  output logic                        gbf_rd_en,
  output logic [GBF_ADDR_WIDTH-1:0]   gbf_rd_addr,
  input  logic [SPI_WIDTH-1:0]        gbf_rd_data,
  input  logic                        config_ready,
  output logic                        config_paulse,
  output logic [3:0]                  config_data,
  output logic [IFSCHEDULE_WIDTH-1:0] IF_schedule,
  input  logic                        wr_ready,
  output logic                        wr_req,
  output logic [SPI_WIDTH-1:0]        wr_data
);

  localparam int OCC_W = $clog2(SKID_DEPTH) + 1;

  tx_state_t                   state_reg, state_next;
  logic [TX_WIDTH-1:0]         n_reg, rd_cnt_reg, wr_cnt_reg;
  logic [GBF_ADDR_WIDTH-1:0]   base_reg, rd_addr_reg;
  logic [3:0]                  config_data_reg;
  logic [IFSCHEDULE_WIDTH-1:0] sched_reg;
  logic                        rd_en_reg, push_reg;
  logic                        busy_reg, done_reg, paulse_reg;

  logic [SPI_WIDTH-1:0] head_data;
  logic [OCC_W-1:0]     occupancy;
  logic [OCC_W:0]       occ_after;
  logic                 issue_ok, prefetch_full, pop;
  logic                 start, issue, cfg_fire;

  sync_skid_fifo #(
    .DEPTH (SKID_DEPTH),
    .WIDTH (SPI_WIDTH)
  ) u_skid (
    .clk_chip     (clk_chip),
    .reset_n_chip (reset_n_chip),
    .push         (push_reg),
    .push_data    (gbf_rd_data),
    .pop          (pop),
    .head_data    (head_data),
    .occupancy    (occupancy)
  );

  assign wr_req  = (state_reg == ST_STREAM) && wr_ready && (occupancy != '0);
  assign pop     = wr_req;
  // Gate the head so an empty buffer never exposes stale storage.
  assign wr_data = (occupancy != '0) ? head_data : '0;

  // The next read decision is registered, so it is judged against the
  // occupancy after this edge plus the read still on the GBF bus
  // (rd_en_reg, whose data lands one edge later). That keeps the buffer
  // at most SKID_DEPTH-1 full while still allowing one read per cycle.
  assign occ_after = {1'b0, occupancy} + {{OCC_W{1'b0}}, push_reg}
                   - {{OCC_W{1'b0}}, pop};
  assign issue_ok  = (rd_cnt_reg < n_reg) &&
                     ((occ_after + {{OCC_W{1'b0}}, rd_en_reg}) <= (OCC_W+1)'(SKID_DEPTH - 2));

  // occupancy >= min(N, SKID_DEPTH-1)
  assign prefetch_full = (TX_WIDTH'(occupancy) >= n_reg) ||
                         (occupancy >= OCC_W'(SKID_DEPTH - 1));

  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    issue      = 1'b0;
    cfg_fire   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (tx_start) begin
          start      = 1'b1;
          state_next = ST_PREFETCH;
        end
      end
      ST_PREFETCH: begin
        issue = issue_ok;
        if (prefetch_full) begin
          state_next = ST_CFG_WAIT;
        end
      end
      ST_CFG_WAIT: begin
        issue = issue_ok;
        if (config_ready) begin
          cfg_fire   = 1'b1;
          state_next = ST_STREAM;
        end
      end
      ST_STREAM: begin
        issue = issue_ok;
        if (wr_req && (wr_cnt_reg == n_reg - TX_WIDTH'(1))) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_chip or negedge reset_n_chip) begin
    if (!reset_n_chip) begin
      state_reg       <= ST_IDLE;
      n_reg           <= '0;
      rd_cnt_reg      <= '0;
      wr_cnt_reg      <= '0;
      base_reg        <= '0;
      rd_addr_reg     <= '0;
      config_data_reg <= '0;
      sched_reg       <= '0;
      rd_en_reg       <= 1'b0;
      push_reg        <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      paulse_reg      <= 1'b0;
    end else begin
      state_reg  <= state_next;
      busy_reg   <= (state_next != ST_IDLE);
      done_reg   <= (state_next == ST_DONE);
      paulse_reg <= cfg_fire;
      // Reads issued before a reset never reach here, so late data is dropped.
      push_reg   <= rd_en_reg;
      if (start) begin
        n_reg           <= TX_WIDTH'(wr_size_of(tx_code));
        base_reg        <= tx_base_addr;
        config_data_reg <= tx_code;
        sched_reg       <= IF_schedule_in;
        wr_cnt_reg      <= '0;
        // Counter cleared and the first read (base + 0) issued together.
        rd_cnt_reg      <= TX_WIDTH'(1);
        rd_en_reg       <= 1'b1;
        rd_addr_reg     <= tx_base_addr;
      end else begin
        rd_en_reg <= issue;
        if (issue) begin
          rd_addr_reg <= base_reg + GBF_ADDR_WIDTH'(rd_cnt_reg);
          rd_cnt_reg  <= rd_cnt_reg + TX_WIDTH'(1);
        end
        if (wr_req) begin
          wr_cnt_reg <= wr_cnt_reg + TX_WIDTH'(1);
        end
      end
    end
  end

  assign tx_busy       = busy_reg;
  assign tx_done       = done_reg;
  assign gbf_rd_en     = rd_en_reg;
  assign gbf_rd_addr   = rd_addr_reg;
  assign config_paulse = paulse_reg;
  assign config_data   = config_data_reg;
  assign IF_schedule   = sched_reg;

endmodule

// File: tb/tb_ofm_tx_feeder.sv
// tb_ofm_tx_feeder
// Directed transfers against a GBF model; expected addresses, words and
// configuration are queued when each transfer is requested and a monitor
// compares them as the DUT presents them.
module tb_ofm_tx_feeder;
  import ofm_tx_feeder_pkg::*;

  localparam int SW = IFSCHEDULE_WIDTH;

  logic          clk_chip = 1'b0;
  logic          reset_n_chip = 1'b0;
  logic          tx_start = 1'b0;
  logic [3:0]    tx_code = 4'h0;
  logic [11:0]   tx_base_addr = 12'h000;
  logic [SW-1:0] IF_schedule_in = '0;
  logic          tx_busy, tx_done, gbf_rd_en, config_paulse, wr_req;
  logic [11:0]   gbf_rd_addr;
  logic [31:0]   gbf_rd_data = 32'h0;
  logic          config_ready = 1'b1;
  logic [3:0]    config_data;
  logic [SW-1:0] IF_schedule;
  logic          wr_ready;
  logic [31:0]   wr_data;

  ofm_tx_feeder #(
    .SPI_WIDTH(32), .GBF_ADDR_WIDTH(12), .TX_WIDTH(20), .SKID_DEPTH(4)
  ) dut (
    .clk_chip(clk_chip), .reset_n_chip(reset_n_chip),
    .tx_start(tx_start), .tx_code(tx_code), .tx_base_addr(tx_base_addr),
    .IF_schedule_in(IF_schedule_in), .tx_busy(tx_busy), .tx_done(tx_done),
    .gbf_rd_en(gbf_rd_en), .gbf_rd_addr(gbf_rd_addr), .gbf_rd_data(gbf_rd_data),
    .config_ready(config_ready), .config_paulse(config_paulse),
    .config_data(config_data), .IF_schedule(IF_schedule),
    .wr_ready(wr_ready), .wr_req(wr_req), .wr_data(wr_data)
  );

  always #5 clk_chip = ~clk_chip;

  function automatic logic [31:0] gbf_word(input logic [11:0] a);
    return {8'hC5, 12'h3A0, a};
  endfunction

  // GBF model: one-cycle read latency.
  always @(posedge clk_chip) begin
    if (gbf_rd_en) gbf_rd_data <= gbf_word(gbf_rd_addr);
  end

  logic [31:0]     data_q[$];
  logic [11:0]     addr_q[$];
  logic [4+SW-1:0] cfg_q[$];
  int              n_q[$];
  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int left = 0;
  bit stream_on = 0;
  bit rdy_mode = 0;

  // wr_ready: held high (mode 0) or toggling every cycle (mode 1).
  initial begin
    wr_ready = 1'b1;
    forever begin
      @(posedge clk_chip); #1;
      if (rdy_mode) wr_ready = ~wr_ready;
      else wr_ready = 1'b1;
    end
  end

  // Monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk_chip);
      if (!reset_n_chip) begin
        stream_on = 0;
        left = 0;
      end else begin
        if (tx_done) done_cnt++;
        if (config_paulse) begin
          checks++;
          if (cfg_q.size() == 0) begin
            failures++;
            $display("FAIL cfg_unexpected got=%h/%h want=none", config_data, IF_schedule);
          end else begin
            logic [4+SW-1:0] exp_cfg;
            exp_cfg = cfg_q.pop_front();
            left = n_q.pop_front();
            stream_on = 1;
            if ({config_data, IF_schedule} !== exp_cfg) begin
              failures++;
              $display("FAIL cfg_data got=%h want=%h", {config_data, IF_schedule}, exp_cfg);
            end else
              $display("cfg   code=%h tag=%h words=%0d", config_data, IF_schedule, left);
          end
        end
        if (gbf_rd_en) begin
          checks++;
          if (addr_q.size() == 0) begin
            failures++;
            $display("FAIL rd_addr_extra got=%h want=none", gbf_rd_addr);
          end else begin
            logic [11:0] exp_a;
            exp_a = addr_q.pop_front();
            if (gbf_rd_addr !== exp_a) begin
              failures++;
              $display("FAIL rd_addr got=%h want=%h", gbf_rd_addr, exp_a);
            end
          end
        end
        if (stream_on && left > 0 && wr_ready) begin
          checks++;
          if (!wr_req) begin
            failures++;
            $display("FAIL underrun got=wr_req0 want=wr_req1 left=%0d", left);
          end
        end
        if (wr_req) begin
          checks++;
          if (data_q.size() == 0) begin
            failures++;
            $display("FAIL wr_extra got=%h want=none", wr_data);
          end else begin
            logic [31:0] exp_d;
            exp_d = data_q.pop_front();
            if (wr_data !== exp_d) begin
              failures++;
              $display("FAIL wr_data got=%h want=%h", wr_data, exp_d);
            end else
              $display("word  data=%h", wr_data);
          end
          if (left > 0) left--;
          if (left == 0) stream_on = 0;
        end
      end
    end
  end

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_tx_busy"}, 32'(tx_busy), 32'd0);
    check_val({tag, "_tx_done"}, 32'(tx_done), 32'd0);
    check_val({tag, "_gbf_rd_en"}, 32'(gbf_rd_en), 32'd0);
    check_val({tag, "_config_paulse"}, 32'(config_paulse), 32'd0);
    check_val({tag, "_wr_req"}, 32'(wr_req), 32'd0);
    check_val({tag, "_gbf_rd_addr"}, 32'(gbf_rd_addr), 32'd0);
    check_val({tag, "_config_data"}, 32'(config_data), 32'd0);
    check_val({tag, "_IF_schedule"}, 32'(IF_schedule), 32'd0);
    check_val({tag, "_wr_data"}, wr_data, 32'd0);
  endtask

  task automatic pulse_start(input logic [3:0] code, input logic [11:0] base, input logic [SW-1:0] tag);
    @(posedge clk_chip); #1;
    tx_code = code; tx_base_addr = base; IF_schedule_in = tag; tx_start = 1'b1;
    @(posedge clk_chip); #1;
    tx_start = 1'b0;
  endtask

  task automatic start_tx(input logic [3:0] code, input logic [11:0] base, input logic [SW-1:0] tag);
    int n;
    logic [11:0] a;
    n = (code == IFCODE_OFM) ? int'(WR_SIZE_OFM) : int'(WR_SIZE_FLGOFM);
    for (int i = 0; i < n; i++) begin
      a = base + 12'(i);
      addr_q.push_back(a);
      data_q.push_back(gbf_word(a));
    end
    cfg_q.push_back({code, tag});
    n_q.push_back(n);
    $display("start code=%h base=%h tag=%h n=%0d", code, base, tag, n);
    pulse_start(code, base, tag);
  endtask

  task automatic wait_done(input string name);
    int d0;
    int k;
    d0 = done_cnt;
    k = 0;
    while (done_cnt == d0 && k < 2000) begin
      @(negedge clk_chip);
      k++;
    end
    checks++;
    if (done_cnt == d0) begin
      failures++;
      $display("FAIL %s_timeout got=no_done want=done", name);
    end
    repeat (5) @(negedge clk_chip);
    check_val({name, "_done_count"}, 32'(done_cnt - d0), 32'd1);
    check_val({name, "_words_left"}, 32'(data_q.size()), 32'd0);
    check_val({name, "_reads_left"}, 32'(addr_q.size()), 32'd0);
    check_val({name, "_busy_after"}, 32'(tx_busy), 32'd0);
    $display("done  %s", name);
  endtask

  task automatic wait_words_below(input int lim);
    int k;
    k = 0;
    while (data_q.size() > lim && k < 500) begin
      @(negedge clk_chip);
      k++;
    end
    checks++;
    if (data_q.size() > lim) begin
      failures++;
      $display("FAIL wait_words got=%0d want<=%0d", data_q.size(), lim);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit bad;
    repeat (3) @(negedge clk_chip);
    check_reset_outputs("por");
    @(posedge clk_chip); #1;
    reset_n_chip = 1'b1;
    repeat (2) @(negedge clk_chip);

    // 1: OFM, wr_ready high, base 0x010
    start_tx(IFCODE_OFM, 12'h010, 8'hA1);
    wait_done("ofm_base010");

    // 2: FLGOFM with wr_ready toggling
    rdy_mode = 1;
    start_tx(IFCODE_FLGOFM, 12'h123, 8'h52);
    wait_done("flgofm_toggle");
    rdy_mode = 0;

    // 3: config_ready withheld 20 cycles after prefetch
    config_ready = 1'b0;
    start_tx(IFCODE_FLGOFM, 12'h300, 8'h3C);
    repeat (8) @(negedge clk_chip);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_chip);
      if (config_paulse || wr_req) bad = 1;
    end
    check_val("cfg_hold_quiet", 32'(bad), 32'd0);
    check_val("cfg_hold_busy", 32'(tx_busy), 32'd1);
    @(posedge clk_chip); #1;
    config_ready = 1'b1;
    wait_done("cfg_wait");

    // 4: address wrap-around
    start_tx(IFCODE_OFM, 12'hFFE, 8'h77);
    wait_done("addr_wrap");

    // 5: reset mid-STREAM, then a fresh transfer
    start_tx(IFCODE_OFM, 12'h100, 8'h11);
    wait_words_below(15);
    @(posedge clk_chip); #2;
    reset_n_chip = 1'b0;
    #1;
    check_reset_outputs("midrst");
    data_q.delete(); addr_q.delete(); cfg_q.delete(); n_q.delete();
    repeat (2) @(posedge clk_chip);
    #1;
    reset_n_chip = 1'b1;
    start_tx(IFCODE_OFM, 12'h200, 8'h22);
    wait_done("after_reset");

    // 6: tx_start during STREAM is ignored
    start_tx(IFCODE_OFM, 12'h040, 8'h66);
    wait_words_below(14);
    pulse_start(IFCODE_FLGOFM, 12'h7C0, 8'h99);
    wait_done("start_ignored");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
